mac_unit_top: RTL and testbench

Pipelined matrix multiply-accumulate block computing C = A × B for an M×K matrix A and a K×N matrix B of unsigned 8-bit elements, producing 16-bit results. It sits behind a host valid/ready handshake:

- The host loads both operand matrices in a single write cycle.
- The block computes with one shared, pipelined MAC datapath.
- The host reads the whole result matrix in a single read cycle.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_pe.sv | 55 +++++
 rtl/mac_unit_top.sv | 152 +++++++++++++++
 tb/tb_mac_unit_top.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared sizes, FSM state encoding and counter-width helper for the matrix MAC block.
package mac_pkg;

    localparam int unsigned DefM     = 4;
    localparam int unsigned DefK     = 4;
    localparam int unsigned DefN     = 4;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAccW  = 2 * DefDataW;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompute,
        StDone
    } state_e;

    // Width of a counter or index that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// Two-stage unsigned multiply/accumulate: product register, then wrapping accumulator.
module mac_pe
    import mac_pkg::*;
#(
    parameter int unsigned InW  = DefDataW,
    parameter int unsigned OutW = DefAccW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [InW-1:0]  a_i,
    input  logic [InW-1:0]  b_i,
    input  logic            valid_i,
    input  logic            clear_acc_i,
    output logic [OutW-1:0] acc_o,
    output logic            acc_valid_o
);

    logic [OutW-1:0] prod_q, prod_d;
    logic [OutW-1:0] acc_q, acc_d;
    logic            prod_valid_q;
    logic            prod_clear_q;
    logic            acc_valid_q;

    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        if (valid_i) begin
            prod_d = OutW'(a_i) * OutW'(b_i);
        end
        // The first term of a dot product restarts the sum instead of adding to it.
        if (prod_valid_q) begin
            acc_d = prod_clear_q ? prod_q : acc_q + prod_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q       <= '0;
            acc_q        <= '0;
            prod_valid_q <= 1'b0;
            prod_clear_q <= 1'b0;
            acc_valid_q  <= 1'b0;
        end else begin
            prod_q       <= prod_d;
            acc_q        <= acc_d;
            prod_valid_q <= valid_i;
            prod_clear_q <= valid_i & clear_acc_i;
            acc_valid_q  <= prod_valid_q;
        end
    end

    assign acc_o       = acc_q;
    assign acc_valid_o = acc_valid_q;

endmodule

// File: rtl/mac_unit_top.sv
// Matrix multiply C = A x B with host valid/ready handshake and one shared pipelined MAC.
module mac_unit_top
    import mac_pkg::*;
#(
    parameter int unsigned param_M            = DefM,
    parameter int unsigned param_K            = DefK,
    parameter int unsigned param_N            = DefN,
    parameter int unsigned DATA_WIDTH_INITIAL = DefDataW,
    parameter int unsigned DATA_WIDTH_FINAL   = 2 * DATA_WIDTH_INITIAL
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          host2block_val,
    output logic                          host2block_rdy,
    input  logic                          a_b_we_ext,
    input  logic [DATA_WIDTH_INITIAL-1:0] a_data_in_ext [param_M*param_K],
    input  logic [DATA_WIDTH_INITIAL-1:0] b_data_in_ext [param_K*param_N],
    input  logic                          block2host_rdy,
    input  logic                          c_re_ext,
    output logic [DATA_WIDTH_FINAL-1:0]   c_data_out_ext [param_M*param_N],
    output logic                          mac_done,
    output logic                          block2host_val
);

    localparam int unsigned MW    = cnt_w(param_M);
    localparam int unsigned KW    = cnt_w(param_K);
    localparam int unsigned NW    = cnt_w(param_N);
    localparam int unsigned AIdxW = cnt_w(param_M * param_K);
    localparam int unsigned BIdxW = cnt_w(param_K * param_N);
    localparam int unsigned CIdxW = cnt_w(param_M * param_N);

    state_e state_q, state_d;

    logic [DATA_WIDTH_INITIAL-1:0] a_q     [param_M*param_K];
    logic [DATA_WIDTH_INITIAL-1:0] b_q     [param_K*param_N];
    logic [DATA_WIDTH_FINAL-1:0]   c_q     [param_M*param_N];
    logic [DATA_WIDTH_FINAL-1:0]   c_out_q [param_M*param_N];

    logic [MW-1:0]    m_q;
    logic [NW-1:0]    n_q;
    logic [KW-1:0]    k_q;
    logic             issue_q;
    logic [1:0]       last_q;
    logic [CIdxW-1:0] wr_idx_q;

    logic                        k_last, n_last, m_last;
    logic                        load_fire, read_fire, c_wr;
    logic [AIdxW-1:0]            a_idx;
    logic [BIdxW-1:0]            b_idx;
    logic [DATA_WIDTH_FINAL-1:0] acc;
    logic                        acc_valid;

    assign k_last = (k_q == KW'(param_K - 1));
    assign n_last = (n_q == NW'(param_N - 1));
    assign m_last = (m_q == MW'(param_M - 1));

    assign a_idx = AIdxW'(32'(m_q) * param_K + 32'(k_q));
    assign b_idx = BIdxW'(32'(n_q) * param_K + 32'(k_q));

    assign load_fire = (state_q == StLoad) & a_b_we_ext;
    assign read_fire = (state_q == StDone) & c_re_ext & block2host_rdy;

    // The end-of-dot-product marker travels alongside the two MAC stages.
    assign c_wr     = acc_valid & last_q[1];
    assign mac_done = (state_q == StCompute) & c_wr
                    & (wr_idx_q == CIdxW'(param_M * param_N - 1));

    assign host2block_rdy = (state_q == StLoad);
    assign block2host_val = (state_q == StDone);
    assign c_data_out_ext = c_out_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (host2block_val) state_d = StLoad;
            StLoad:    if (a_b_we_ext)     state_d = StCompute;
            StCompute: if (mac_done)       state_d = StDone;
            StDone:    if (read_fire)      state_d = StIdle;
            default:                       state_d = StIdle;
        endcase
    end

    mac_pe #(
        .InW  (DATA_WIDTH_INITIAL),
        .OutW (DATA_WIDTH_FINAL)
    ) u_mac_pe (
        .clk_i       (clk),
        .rst_i       (rstn),
        .a_i         (a_q[a_idx]),
        .b_i         (b_q[b_idx]),
        .valid_i     (issue_q),
        .clear_acc_i (k_q == '0),
        .acc_o       (acc),
        .acc_valid_o (acc_valid)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= StIdle;
            a_q      <= '{default: '0};
            b_q      <= '{default: '0};
            c_q      <= '{default: '0};
            c_out_q  <= '{default: '0};
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            issue_q  <= 1'b0;
            last_q   <= '0;
            wr_idx_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= {last_q[0], issue_q & k_last};
            if (load_fire) begin
                a_q      <= a_data_in_ext;
                b_q      <= b_data_in_ext;
                c_q      <= '{default: '0};
                m_q      <= '0;
                n_q      <= '0;
                k_q      <= '0;
                issue_q  <= 1'b1;
                wr_idx_q <= '0;
            end else begin
                // Issue order: k innermost, then n, then m.
                if (issue_q) begin
                    if (!k_last) begin
                        k_q <= k_q + 1'b1;
                    end else begin
                        k_q <= '0;
                        if (!n_last) begin
                            n_q <= n_q + 1'b1;
                        end else begin
                            n_q <= '0;
                            if (m_last) begin
                                issue_q <= 1'b0;
                            end else begin
                                m_q <= m_q + 1'b1;
                            end
                        end
                    end
                end
                if (c_wr) begin
                    c_q[wr_idx_q] <= acc;
                    wr_idx_q      <= wr_idx_q + 1'b1;
                end
            end
            if (read_fire) begin
                c_out_q <= c_q;
            end
        end
    end

endmodule

// File: tb/tb_mac_unit_top.sv
// Randomised and directed checks of mac_unit_top against a plain-arithmetic matrix product.
module tb_mac_unit_top;

    localparam int M = 4;
    localparam int K = 4;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        host2block_val = 1'b0;
    logic        host2block_rdy;
    logic        a_b_we_ext = 1'b0;
    logic [7:0]  a_data_in_ext [M*K];
    logic [7:0]  b_data_in_ext [K*N];
    logic        block2host_rdy = 1'b0;
    logic        c_re_ext = 1'b0;
    logic [15:0] c_data_out_ext [M*N];
    logic        mac_done;
    logic        block2host_val;

    logic [15:0] exp_c  [M*N];
    logic [15:0] prev_c [M*N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_unit_top u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .host2block_val (host2block_val),
        .host2block_rdy (host2block_rdy),
        .a_b_we_ext     (a_b_we_ext),
        .a_data_in_ext  (a_data_in_ext),
        .b_data_in_ext  (b_data_in_ext),
        .block2host_rdy (block2host_rdy),
        .c_re_ext       (c_re_ext),
        .c_data_out_ext (c_data_out_ext),
        .mac_done       (mac_done),
        .block2host_val (block2host_val)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // C(m,n) = sum_k A(m,k) * B(k,n), B supplied transposed, wrapped to 16 bits.
    function automatic void model();
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                logic [15:0] s;
                s = 16'd0;
                for (int k = 0; k < K; k++) begin
                    s = s + 16'(a_data_in_ext[m*K+k]) * 16'(b_data_in_ext[n*K+k]);
                end
                exp_c[m*N+n] = s;
            end
        end
    endfunction

    task automatic check_held(input string tag);
        for (int i = 0; i < M*N; i++) begin
            check_val($sformatf("%s[%0d]", tag, i), 32'(c_data_out_ext[i]), 32'(prev_c[i]));
        end
    endtask

    // Request, then present operands with the write strobe; returns with the strobe high.
    task automatic launch();
        @(negedge clk);
        host2block_val = 1'b1;
        @(negedge clk);
        host2block_val = 1'b0;
        check_val("load_rdy", 32'(host2block_rdy), 32'd1);
        a_b_we_ext = 1'b1;
    endtask

    task automatic wait_done();
        int  cycles;
        bit  seen;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 200) begin
            @(negedge clk);
            a_b_we_ext = 1'b0;
            cycles++;
            if (mac_done) seen = 1'b1;
        end
        check_val("done_latency", 32'(cycles), 32'd66);
    endtask

    task automatic read_result(input bit stall);
        @(negedge clk);
        check_val("done_val", 32'(block2host_val), 32'd1);
        check_val("done_pulse_end", 32'(mac_done), 32'd0);
        check_held("held_before_read");
        if (stall) begin
            c_re_ext       = 1'b1;
            block2host_rdy = 1'b0;
            @(negedge clk);
            check_val("stall_val", 32'(block2host_val), 32'd1);
            check_held("held_on_stall");
        end
        c_re_ext       = 1'b1;
        block2host_rdy = 1'b1;
        @(negedge clk);
        c_re_ext       = 1'b0;
        block2host_rdy = 1'b0;
        check_val("post_read_val", 32'(block2host_val), 32'd0);
        check_val("post_read_rdy", 32'(host2block_rdy), 32'd0);
        for (int i = 0; i < M*N; i++) begin
            check_val($sformatf("c[%0d]", i), 32'(c_data_out_ext[i]), 32'(exp_c[i]));
        end
        prev_c = exp_c;
    endtask

    task automatic load_nominal();
        for (int i = 0; i < M*K; i++) a_data_in_ext[i] = 8'(i);
        for (int k = 0; k < K; k++) begin
            for (int n = 0; n < N; n++) b_data_in_ext[n*K+k] = 8'(k*N + n);
        end
    endtask

    task automatic check_nominal_consts(input string tag);
        check_val({tag, "_c0"}, 32'(c_data_out_ext[0]), 32'd56);
        check_val({tag, "_c1"}, 32'(c_data_out_ext[1]), 32'd62);
        check_val({tag, "_c4"}, 32'(c_data_out_ext[4]), 32'd152);
        check_val({tag, "_c15"}, 32'(c_data_out_ext[15]), 32'd506);
    endtask

    initial begin
        for (int i = 0; i < M*K; i++) a_data_in_ext[i] = 8'd0;
        for (int i = 0; i < K*N; i++) b_data_in_ext[i] = 8'd0;
        for (int i = 0; i < M*N; i++) prev_c[i] = 16'd0;

        // Reset
        repeat (5) @(negedge clk);
        check_val("rst_h2b_rdy", 32'(host2block_rdy), 32'd0);
        check_val("rst_b2h_val", 32'(block2host_val), 32'd0);
        check_val("rst_done", 32'(mac_done), 32'd0);
        check_held("rst_c");
        rstn = 1'b0;

        // Write strobe while idle must not start anything
        @(negedge clk);
        a_b_we_ext = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("idle_we_rdy", 32'(host2block_rdy), 32'd0);
            check_val("idle_we_done", 32'(mac_done), 32'd0);
            check_val("idle_we_val", 32'(block2host_val), 32'd0);
        end
        a_b_we_ext = 1'b0;

        // Nominal run
        load_nominal();
        model();
        launch();
        wait_done();
        read_result(1'b1);
        check_nominal_consts("nom");

        // Back-to-back: identity A gives C equal to B
        for (int m = 0; m < M; m++) begin
            for (int k = 0; k < K; k++) a_data_in_ext[m*K+k] = (m == k) ? 8'd1 : 8'd0;
        end
        for (int i = 0; i < K*N; i++) b_data_in_ext[i] = 8'($urandom_range(0, 255));
        model();
        launch();
        wait_done();
        read_result(1'b1);
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                check_val($sformatf("ident[%0d]", m*N+n), 32'(c_data_out_ext[m*N+n]),
                          32'(b_data_in_ext[n*K+m]));
            end
        end

        // Overflow: read accepted in the first DONE cycle
        for (int i = 0; i < M*K; i++) a_data_in_ext[i] = 8'd255;
        for (int i = 0; i < K*N; i++) b_data_in_ext[i] = 8'd255;
        model();
        launch();
        wait_done();
        read_result(1'b0);
        check_val("ovf_c0", 32'(c_data_out_ext[0]), 32'd63492);
        check_val("ovf_c15", 32'(c_data_out_ext[15]), 32'd63492);

        // Random operands
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < M*K; i++) a_data_in_ext[i] = 8'($urandom);
            for (int i = 0; i < K*N; i++) b_data_in_ext[i] = 8'($urandom);
            model();
            launch();
            wait_done();
            read_result(1'($urandom_range(0, 1)));
        end

        // Reset in the middle of COMPUTE
        load_nominal();
        launch();
        @(negedge clk);
        a_b_we_ext = 1'b0;
        repeat (20) @(negedge clk);
        #2 rstn = 1'b1;
        #1;
        check_val("midrst_h2b_rdy", 32'(host2block_rdy), 32'd0);
        check_val("midrst_b2h_val", 32'(block2host_val), 32'd0);
        check_val("midrst_done", 32'(mac_done), 32'd0);
        for (int i = 0; i < M*N; i++) prev_c[i] = 16'd0;
        check_held("midrst_c");
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_val("midrst_idle_rdy", 32'(host2block_rdy), 32'd0);

        // Full nominal run after the abort
        load_nominal();
        model();
        launch();
        wait_done();
        read_result(1'b0);
        check_nominal_consts("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
